raster_pair_streamer: RTL and testbench

Source-side raster generator for the depth-from-defocus pipeline. It accepts rho-plus/rho-minus uint8 pixel pairs over a ready/valid handshake, e.g. from a DMA FIFO. It emits them as the valid-qualified col/row raster stream that the dual-scale depth pipeline consumes. It inserts programmable horizontal and vertical blanking so downstream line buffers and alignment stages can drain between lines and frames.

---
 rtl/raster_streamer_pkg.sv | 35 +++
 rtl/raster_pair_streamer_if.sv | 32 +++
 rtl/raster_coord_counter.sv | 61 ++++++
 rtl/raster_pair_streamer.sv | 198 +++++++++++++++++++
 tb/tb_raster_pair_streamer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/raster_streamer_pkg.sv
// ============================================================================
// Module   : raster_streamer_pkg
// Purpose  : Shared types and helpers for the raster pair streamer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package raster_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0] plus;
        logic [7:0] minus;
    } pixel_pair_t;

    typedef logic [15:0] coord_t;

    localparam int unsigned c_coord_max = 65535;

    // Blank counter wide enough for the larger of the two blanking loads.
    function automatic int unsigned blank_cnt_width(input int unsigned h, input int unsigned v);
        int unsigned m;
        m = (h > v) ? h : v;
        return (m == 0) ? 1 : $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/raster_pair_streamer_if.sv
// ============================================================================
// Module   : raster_pair_streamer_if
// Purpose  : Pixel-pair input handshake and raster output stream bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface raster_pair_streamer_if;
    import raster_streamer_pkg::*;

    logic [7:0] pix_plus;
    logic [7:0] pix_minus;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] rho_plus;
    logic [7:0] rho_minus;
    coord_t     col;
    coord_t     row;
    logic       valid;

    modport master (
        output pix_plus, pix_minus, pix_valid,
        input  pix_ready, rho_plus, rho_minus, col, row, valid
    );

    modport slave (
        input  pix_plus, pix_minus, pix_valid,
        output pix_ready, rho_plus, rho_minus, col, row, valid
    );
endinterface

`default_nettype wire

// File: rtl/raster_coord_counter.sv
// ============================================================================
// Module   : raster_coord_counter
// Purpose  : Column/row position counter for one raster frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_coord_counter
    import raster_streamer_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = 640,
    parameter int unsigned IMAGE_HEIGHT = 480
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic advance_i,
    input  wire logic clear_i,
    output coord_t    col_o,
    output coord_t    row_o,
    output logic      last_in_row_o,
    output logic      last_in_frame_o
);
    localparam coord_t c_last_col = coord_t'(IMAGE_WIDTH - 1);
    localparam coord_t c_last_row = coord_t'(IMAGE_HEIGHT - 1);

    coord_t col_q, col_d;
    coord_t row_q, row_d;

    assign last_in_row_o   = (col_q == c_last_col);
    assign last_in_frame_o = last_in_row_o && (row_q == c_last_row);
    assign col_o           = col_q;
    assign row_o           = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (last_in_row_o) begin
                col_d = '0;
                row_d = last_in_frame_o ? '0 : row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

`default_nettype wire

// File: rtl/raster_pair_streamer.sv
// ============================================================================
// Module   : raster_pair_streamer
// Purpose  : Turns handshaked rho+/rho- pixel pairs into a blanked raster
//            stream. Define RASTER_STREAMER_TEST_PATTERN_EN for a built-in
//            coordinate test pattern instead of the pixel input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_pair_streamer
    import raster_streamer_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = 640,
    parameter int unsigned IMAGE_HEIGHT = 480,
    parameter int unsigned H_BLANK      = 16,
    parameter int unsigned V_BLANK      = 10240
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    input  wire logic              start_i,
    input  wire logic              continuous_i,
    raster_pair_streamer_if.slave  px,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic [31:0]            stall_cycles_o
);
    if (IMAGE_WIDTH > c_coord_max || IMAGE_HEIGHT > c_coord_max) begin : g_dim_check
        $error("raster_pair_streamer: IMAGE_WIDTH/IMAGE_HEIGHT must be <= 65535");
    end

    localparam int unsigned c_blank_w = blank_cnt_width(H_BLANK, V_BLANK);
    localparam logic [c_blank_w-1:0] c_h_load = c_blank_w'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [c_blank_w-1:0] c_v_load = c_blank_w'((V_BLANK > 0) ? V_BLANK - 1 : 0);
    localparam logic [c_blank_w-1:0] c_blank_one = c_blank_w'(1);

    state_e                 state_q, state_d;
    logic [c_blank_w-1:0]   blank_q, blank_d;
    pixel_pair_t            pix_q, pix_d;
    coord_t                 col_q, col_d;
    coord_t                 row_q, row_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [31:0]            stall_q, stall_d;

    logic                   w_active;
    logic                   w_accept;
    logic                   w_stall;
    logic                   w_coord_clear;
    logic                   w_stall_clear;
    logic                   w_frame_end;
    pixel_pair_t            w_pixel;
    coord_t                 w_col;
    coord_t                 w_row;
    logic                   w_last_in_row;
    logic                   w_last_in_frame;

    assign w_active = (state_q == ST_ACTIVE);

`ifdef RASTER_STREAMER_TEST_PATTERN_EN
    logic w_unused_pix;
    assign w_unused_pix  = ^{px.pix_plus, px.pix_minus, px.pix_valid};
    assign w_accept      = w_active;
    assign w_stall       = 1'b0;
    assign w_pixel.plus  = w_col[7:0] ^ w_row[7:0];
    assign w_pixel.minus = w_col[7:0] + w_row[7:0];
    assign px.pix_ready  = 1'b0;
`else
    assign w_accept      = w_active && px.pix_valid;
    assign w_stall       = w_active && !px.pix_valid;
    assign w_pixel.plus  = px.pix_plus;
    assign w_pixel.minus = px.pix_minus;
    assign px.pix_ready  = w_active;
`endif

    raster_coord_counter #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT)
    ) u_coord (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .advance_i       (w_accept),
        .clear_i         (w_coord_clear),
        .col_o           (w_col),
        .row_o           (w_row),
        .last_in_row_o   (w_last_in_row),
        .last_in_frame_o (w_last_in_frame)
    );

    always_comb begin
        state_d       = state_q;
        blank_d       = blank_q;
        w_coord_clear = 1'b0;
        w_stall_clear = 1'b0;
        w_frame_end   = 1'b0;
        done_d        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d       = ST_ACTIVE;
                    w_coord_clear = 1'b1;
                    w_stall_clear = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_accept && w_last_in_row) begin
                    if (w_last_in_frame) begin
                        if (V_BLANK == 0) begin
                            w_frame_end = 1'b1;
                        end else begin
                            state_d = ST_VBLANK;
                            blank_d = c_v_load;
                        end
                    end else if (H_BLANK != 0) begin
                        state_d = ST_HBLANK;
                        blank_d = c_h_load;
                    end
                end
            end
            ST_HBLANK: begin
                if (blank_q == '0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    blank_d = blank_q - c_blank_one;
                end
            end
            ST_VBLANK: begin
                if (blank_q == '0) begin
                    w_frame_end = 1'b1;
                end else begin
                    blank_d = blank_q - c_blank_one;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A finished frame either rearms immediately or parks in IDLE.
        if (w_frame_end) begin
            done_d = 1'b1;
            if (continuous_i) begin
                state_d       = ST_ACTIVE;
                w_coord_clear = 1'b1;
                w_stall_clear = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        valid_d = w_accept;
        pix_d   = w_accept ? w_pixel : pix_q;
        col_d   = w_accept ? w_col   : col_q;
        row_d   = w_accept ? w_row   : row_q;
        busy_d  = (state_q != ST_IDLE);
        stall_d = stall_q;
        if (w_stall_clear) begin
            stall_d = '0;
        end else if (w_stall && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            blank_q <= '0;
            pix_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            pix_q   <= pix_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            stall_q <= stall_d;
        end
    end

    assign px.rho_plus     = pix_q.plus;
    assign px.rho_minus    = pix_q.minus;
    assign px.col          = col_q;
    assign px.row          = row_q;
    assign px.valid        = valid_q;
    assign busy_o          = busy_q;
    assign frame_done_o    = done_q;
    assign stall_cycles_o  = stall_q;
endmodule

`default_nettype wire

// File: tb/tb_raster_pair_streamer.sv
// ============================================================================
// Module   : tb_raster_pair_streamer
// Purpose  : Self-checking bench for raster_pair_streamer (two blanking setups).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_raster_pair_streamer;
    import raster_streamer_pkg::*;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int HB_A = 2;
    localparam int VB_A = 3;
    localparam int HB_B = 0;
    localparam int VB_B = 0;
`ifdef RASTER_STREAMER_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        cont;
    logic        sel;
    logic [7:0]  drv_plus;
    logic [7:0]  drv_minus;
    logic        drv_valid;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] stall_a, stall_b;

    raster_pair_streamer_if if_a ();
    raster_pair_streamer_if if_b ();

    assign if_a.pix_plus  = drv_plus;
    assign if_a.pix_minus = drv_minus;
    assign if_a.pix_valid = drv_valid;
    assign if_b.pix_plus  = drv_plus;
    assign if_b.pix_minus = drv_minus;
    assign if_b.pix_valid = drv_valid;

    raster_pair_streamer #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .H_BLANK(HB_A), .V_BLANK(VB_A)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .continuous_i(cont),
        .px(if_a.slave), .busy_o(busy_a), .frame_done_o(done_a), .stall_cycles_o(stall_a)
    );

    raster_pair_streamer #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .H_BLANK(HB_B), .V_BLANK(VB_B)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .continuous_i(cont),
        .px(if_b.slave), .busy_o(busy_b), .frame_done_o(done_b), .stall_cycles_o(stall_b)
    );

    logic        obs_valid, obs_ready, obs_busy, obs_done;
    logic [7:0]  obs_plus, obs_minus;
    logic [15:0] obs_col, obs_row;
    logic [31:0] obs_stall;

    always_comb begin
        obs_valid = sel ? if_b.valid     : if_a.valid;
        obs_ready = sel ? if_b.pix_ready : if_a.pix_ready;
        obs_busy  = sel ? busy_b         : busy_a;
        obs_done  = sel ? done_b         : done_a;
        obs_plus  = sel ? if_b.rho_plus  : if_a.rho_plus;
        obs_minus = sel ? if_b.rho_minus : if_a.rho_minus;
        obs_col   = sel ? if_b.col       : if_a.col;
        obs_row   = sel ? if_b.row       : if_a.row;
        obs_stall = sel ? stall_b        : stall_a;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs(input logic v);
        drv_valid = v;
        drv_plus  = 8'($urandom);
        drv_minus = 8'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, obs_valid}, 32'd0);
        check({tag, "_pix"},   {16'd0, obs_plus, obs_minus}, 32'd0);
        check({tag, "_pos"},   {obs_col, obs_row}, 32'd0);
        check({tag, "_ctl"},   {29'd0, obs_busy, obs_done, obs_ready}, 32'd0);
        check({tag, "_stall"}, obs_stall, 32'd0);
    endtask

    // Drives one frame pixel by pixel. Expected positions come from the beat
    // index (col = k mod W, row = k div W) and blank lengths from the setup.
    task automatic run_frame(input bit do_start, input bit cont_mode, input bit rand_stalls,
                             input int abort_at, input int stall_k, input int stall_n);
        int hb, vb, stall_exp, d, c, r;
        logic [7:0] ep, em;
        hb = sel ? HB_B : HB_A;
        vb = sel ? VB_B : VB_A;
        stall_exp = 0;
        cont = cont_mode;
        if (do_start) begin
            junk_inputs(1'b0);
            start = 1'b1;
            step();
            start = 1'b0;
        end
        for (int k = 0; k < W * H; k++) begin
            c = k % W;
            r = k / W;
            if (TP) d = 0;
            else if (k == stall_k) d = stall_n;
            else d = rand_stalls ? int'($urandom_range(0, 2)) : 0;
            for (int s = 0; s < d; s++) begin
                junk_inputs(1'b0);
                start = 1'($urandom_range(0, 1));
                check("ready_in_stall", {31'd0, obs_ready}, 32'd1);
                step();
                stall_exp++;
                check("valid_in_stall", {31'd0, obs_valid}, 32'd0);
            end
            junk_inputs(1'b1);
            start = 1'($urandom_range(0, 1));
            if (k == abort_at) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                start = 1'b0;
                drv_valid = 1'b0;
                check_all_zero("abort");
                return;
            end
            ep = TP ? 8'(c ^ r) : drv_plus;
            em = TP ? 8'(c + r) : drv_minus;
            check("ready_active", {31'd0, obs_ready}, TP ? 32'd0 : 32'd1);
            step();
            check("beat_valid", {31'd0, obs_valid}, 32'd1);
            check("beat_col",   {16'd0, obs_col}, 32'(c));
            check("beat_row",   {16'd0, obs_row}, 32'(r));
            check("beat_pix",   {16'd0, obs_plus, obs_minus}, {16'd0, ep, em});
            check("beat_done",  {31'd0, obs_done}, {31'd0, (k == W * H - 1) && (vb == 0)});
            if (c == W - 1 && r < H - 1) begin
                for (int i = 0; i < hb; i++) begin
                    junk_inputs(1'b1);
                    check("ready_hblank", {31'd0, obs_ready}, 32'd0);
                    step();
                    check("valid_hblank", {31'd0, obs_valid}, 32'd0);
                end
            end
        end
        for (int i = 0; i < vb; i++) begin
            junk_inputs(1'b1);
            start = 1'($urandom_range(0, 1));
            check("ready_vblank", {31'd0, obs_ready}, 32'd0);
            step();
            check("valid_vblank", {31'd0, obs_valid}, 32'd0);
            check("done_vblank",  {31'd0, obs_done}, {31'd0, i == vb - 1});
        end
        start = 1'b0;
        if (cont_mode) begin
            check("stall_restart", obs_stall, 32'd0);
        end else begin
            check("busy_at_done", {31'd0, obs_busy}, 32'd1);
            junk_inputs(1'b0);
            step();
            check("busy_after", {31'd0, obs_busy}, 32'd0);
            check("done_after", {31'd0, obs_done}, 32'd0);
            check("ready_idle", {31'd0, obs_ready}, 32'd0);
            check("stall_total", obs_stall, 32'(stall_exp));
        end
    endtask

    initial begin
        sel   = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        junk_inputs(1'b0);
        step();
        step();
        check_all_zero("reset_a");
        sel = 1'b1;
        check_all_zero("reset_b");
        sel = 1'b0;
        rst_n = 1'b1;
        step();

        run_frame(1'b1, 1'b0, 1'b0, -1, -1, 0);
        run_frame(1'b1, 1'b0, 1'b0, -1, 2, 5);
        run_frame(1'b1, 1'b0, 1'b1, -1, -1, 0);
        run_frame(1'b1, 1'b1, 1'b1, -1, -1, 0);
        run_frame(1'b0, 1'b0, 1'b0, -1, -1, 0);
        run_frame(1'b1, 1'b0, 1'b0, 6, -1, 0);
        run_frame(1'b1, 1'b0, 1'b0, -1, -1, 0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sel = 1'b1;
        run_frame(1'b1, 1'b0, 1'b1, -1, -1, 0);
        run_frame(1'b1, 1'b1, 1'b0, -1, 1, 3);
        run_frame(1'b0, 1'b0, 1'b1, -1, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
